// File: rtl/lcd_cmd_seq.sv
// rtl/lcd_cmd_seq.sv - queues host LCD commands and issues them one at a time to the LCD controller
//
// Purpose:
//   Sits directly upstream of the LCD image controller. Host commands enter
//   a small FIFO through a valid/ready handshake. The sequencer hands them to
//   the controller one at a time and waits for each one to finish. The write
//   command (code 0) closes the input side. Once the controller reports done,
//   the sequence is flagged complete.
//
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   in_cmd, in_valid        host command code and valid
//   in_ready                host handshake ready (!full && !closed)
//   lcd_cmd, lcd_cmd_valid  registered command and one-cycle issue strobe
//   lcd_busy, lcd_done      controller status
//   fifo_count              current FIFO occupancy
//   cmd_drop                pulse: an illegal code (12..15) was accepted and discarded
//   ack_err                 pulse: the controller never raised busy after an issue
//   issued_cnt              saturating count of issued commands
//   seq_done                sticky: the write was issued and the controller reported done

module lcd_cmd_seq #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        in_cmd,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [3:0]        lcd_cmd,
  output logic              lcd_cmd_valid,
  input  logic              lcd_busy,
  input  logic              lcd_done,
  output logic [ADDR_W:0]   fifo_count,
  output logic              cmd_drop,
  output logic              ack_err,
  output logic [7:0]        issued_cnt,
  output logic              seq_done
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ISSUE    = 3'd1;
  localparam logic [2:0] S_WAIT_ACK = 3'd2;
  localparam logic [2:0] S_WAIT_REL = 3'd3;
  localparam logic [2:0] S_FINISH   = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam int TIMER_W = $clog2(ACK_TIMEOUT) + 1;
  // The timer counts WAIT_ACK cycles with busy still low. The incremented
  // value would reach ACK_TIMEOUT-1 here, so the error fires on this cycle.
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ACK_TIMEOUT - 2);

  logic [2:0]         state_q, state_d;
  logic [ADDR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]    rd_ptr_q, rd_ptr_d;
  logic               closed_q, closed_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [3:0]         cmd_q, cmd_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic               drop_q, drop_d;
  logic               ack_err_q, ack_err_d;
  logic [7:0]         issued_q, issued_d;
  logic               seq_done_q, seq_done_d;

  logic [3:0]         mem_q [DEPTH];

  logic empty, full, push_hs, push_store, pop;

  // The extra pointer bit separates the full case from the empty case when the
  // address bits match.
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                      (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign in_ready   = !full && !closed_q;
  assign push_hs    = in_valid && in_ready;
  assign push_store = push_hs && (in_cmd <= 4'd11);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    ack_err_d   = 1'b0;
    issued_d    = issued_q;
    seq_done_d  = seq_done_q;
    pop         = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A raised done outside FINISH stalls issuing.
        if (!empty && !lcd_busy && !lcd_done) begin
          pop         = 1'b1;
          cmd_d       = mem_q[rd_ptr_q[ADDR_W-1:0]];
          cmd_valid_d = 1'b1;
          if (issued_q != 8'hFF) begin
            issued_d = issued_q + 8'd1;
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd_q == 4'd0) begin
          state_d = S_FINISH;
        end else begin
          timer_d = '0;
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (lcd_busy) begin
          state_d = S_WAIT_REL;
        end else if (timer_q == TIMER_LAST) begin
          ack_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_WAIT_REL: begin
        if (!lcd_busy) begin
          state_d = S_IDLE;
        end
      end
      S_FINISH: begin
        if (lcd_done) begin
          seq_done_d = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(push_store);
    rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(pop);
    closed_d = closed_q || (push_hs && (in_cmd == 4'd0));
    drop_d   = push_hs && (in_cmd >= 4'd12);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      closed_q    <= 1'b0;
      timer_q     <= '0;
      cmd_q       <= 4'd0;
      cmd_valid_q <= 1'b0;
      drop_q      <= 1'b0;
      ack_err_q   <= 1'b0;
      issued_q    <= 8'd0;
      seq_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      closed_q    <= closed_d;
      timer_q     <= timer_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      drop_q      <= drop_d;
      ack_err_q   <= ack_err_d;
      issued_q    <= issued_d;
      seq_done_q  <= seq_done_d;
    end
  end

  // Storage needs no reset: the cleared pointers make old contents unreachable.
  always_ff @(posedge clk) begin
    if (push_store) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= in_cmd;
    end
  end

  assign lcd_cmd       = cmd_q;
  assign lcd_cmd_valid = cmd_valid_q;
  assign fifo_count    = wr_ptr_q - rd_ptr_q;
  assign cmd_drop      = drop_q;
  assign ack_err       = ack_err_q;
  assign issued_cnt    = issued_q;
  assign seq_done      = seq_done_q;

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// tb/tb_lcd_cmd_seq.sv - self-checking bench for lcd_cmd_seq

module tb_lcd_cmd_seq;

  localparam int DEPTH       = 16;
  localparam int ACK_TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] in_cmd = 4'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] lcd_cmd;
  logic       lcd_cmd_valid;
  logic       lcd_busy;
  logic       lcd_done = 1'b0;
  logic [4:0] fifo_count;
  logic       cmd_drop;
  logic       ack_err;
  logic [7:0] issued_cnt;
  logic       seq_done;

  logic force_busy = 1'b1;
  logic auto_ack   = 1'b1;
  logic ack_pulse  = 1'b0;
  logic valid_prev = 1'b0;
  assign lcd_busy = force_busy | ack_pulse;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int iss_cmd[$];
  int iss_cyc[$];
  int err_cyc[$];
  int drop_cnt = 0;

  lcd_cmd_seq #(.DEPTH(DEPTH), .ADDR_W(4), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .in_cmd(in_cmd), .in_valid(in_valid),
    .in_ready(in_ready), .lcd_cmd(lcd_cmd), .lcd_cmd_valid(lcd_cmd_valid),
    .lcd_busy(lcd_busy), .lcd_done(lcd_done), .fifo_count(fifo_count),
    .cmd_drop(cmd_drop), .ack_err(ack_err), .issued_cnt(issued_cnt),
    .seq_done(seq_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  // Model: a queue of pending codes plus a description of where the current
  // command is in its life (waiting for queue, strobing, awaiting ack, etc).
  localparam int PH_WAITQ = 0, PH_STROBE = 1, PH_ACK = 2, PH_REL = 3, PH_FIN = 4, PH_END = 5;
  int mq[$];
  bit m_closed, m_valid, m_drop, m_err, m_seq;
  int m_phase, m_ack_left, m_cmd, m_issued;

  task automatic model_reset();
    mq.delete();
    m_closed = 0; m_valid = 0; m_drop = 0; m_err = 0; m_seq = 0;
    m_phase = PH_WAITQ; m_ack_left = 0; m_cmd = 0; m_issued = 0;
  endtask

  task automatic model_step(input bit v, input int c, input bit busy, input bit done);
    bit hs;
    hs = v && (mq.size() < DEPTH) && !m_closed;
    m_valid = 0;
    m_err   = 0;
    m_drop  = hs && (c >= 12);
    case (m_phase)
      PH_WAITQ:
        if (mq.size() > 0 && !busy && !done) begin
          m_cmd = mq.pop_front();
          m_valid = 1;
          if (m_issued < 255) m_issued++;
          m_phase = PH_STROBE;
        end
      PH_STROBE:
        if (m_cmd == 0) m_phase = PH_FIN;
        else begin
          m_phase = PH_ACK;
          m_ack_left = ACK_TIMEOUT - 1;
        end
      PH_ACK:
        if (busy) m_phase = PH_REL;
        else begin
          m_ack_left--;
          if (m_ack_left == 0) begin
            m_err = 1;
            m_phase = PH_WAITQ;
          end
        end
      PH_REL:
        if (!busy) m_phase = PH_WAITQ;
      PH_FIN:
        if (done) begin
          m_seq = 1;
          m_phase = PH_END;
        end
      default: ;
    endcase
    if (hs && c < 12) begin
      mq.push_back(c);
      if (c == 0) m_closed = 1;
    end
  endtask

  // Compare process: advance the model on every edge, check just after it.
  initial begin : compare
    bit s_v, s_b, s_d, s_r;
    int s_c;
    forever begin
      @(posedge clk);
      cyc++;
      s_v = in_valid; s_c = int'(in_cmd); s_b = lcd_busy; s_d = lcd_done; s_r = reset;
      if (s_r) model_reset();
      else model_step(s_v, s_c, s_b, s_d);
      #1;
      chk("in_ready", in_ready, (mq.size() < DEPTH) && !m_closed);
      chk("fifo_count", fifo_count, mq.size());
      chk("lcd_cmd", lcd_cmd, m_cmd);
      chk("lcd_cmd_valid", lcd_cmd_valid, m_valid);
      chk("cmd_drop", cmd_drop, m_drop);
      chk("ack_err", ack_err, m_err);
      chk("issued_cnt", issued_cnt, m_issued);
      chk("seq_done", seq_done, m_seq);
    end
  end

  // Controller stand-in: busy for one cycle, one cycle after each strobe.
  // Also logs strobes, drops and ack errors by cycle.
  initial begin : ctrl
    forever begin
      @(negedge clk);
      ack_pulse  = auto_ack && valid_prev;
      valid_prev = lcd_cmd_valid;
      if (lcd_cmd_valid) begin
        iss_cmd.push_back(int'(lcd_cmd));
        iss_cyc.push_back(cyc);
      end
      if (cmd_drop) drop_cnt++;
      if (ack_err) err_cyc.push_back(cyc);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [3:0] c);
    in_cmd = c;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin : stim
    int base, e0, d0;
    cycles(2);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_fifo_count", fifo_count, 0);
    chk("reset_cmd_valid", lcd_cmd_valid, 0);
    chk("reset_issued_cnt", issued_cnt, 0);
    reset = 1'b0;

    // Commands queue behind a busy controller, then issue in order.
    push(4'd1); push(4'd4); push(4'd7);
    cycles(61);
    chk("t1_count", fifo_count, 3);
    chk("t1_no_issue", iss_cmd.size(), 0);
    force_busy = 1'b0;
    cycles(20);
    chk("t1_n_issued", iss_cmd.size(), 3);
    if (iss_cmd.size() == 3) begin
      chk("t1_cmd0", iss_cmd[0], 1);
      chk("t1_cmd1", iss_cmd[1], 4);
      chk("t1_cmd2", iss_cmd[2], 7);
      chk("t1_gap01", iss_cyc[1] - iss_cyc[0], 4);
      chk("t1_gap12", iss_cyc[2] - iss_cyc[1], 4);
    end
    chk("t1_issued_cnt", issued_cnt, 3);

    // Fill to full with 18 offered legal commands.
    force_busy = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      in_cmd = 4'((i % 11) + 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("t2_count_full", fifo_count, 16);
    chk("t2_in_ready_low", in_ready, 0);
    base = iss_cmd.size();
    force_busy = 1'b0;
    cycles(6);
    chk("t2_in_ready_back", in_ready, 1);
    cycles(80);
    chk("t2_issued_cnt", issued_cnt, 19);
    chk("t2_drained", fifo_count, 0);
    if (iss_cmd.size() == base + 16) chk("t2_last_cmd", iss_cmd[base + 15], 5);
    else chk("t2_issue_total", iss_cmd.size() - base, 16);

    // Illegal code is discarded with a drop pulse.
    force_busy = 1'b1;
    d0 = drop_cnt;
    push(4'd13); push(4'd5);
    cycles(2);
    chk("t3_drop_once", drop_cnt - d0, 1);
    chk("t3_count", fifo_count, 1);
    base = iss_cmd.size();
    force_busy = 1'b0;
    cycles(10);
    chk("t3_one_issue", iss_cmd.size() - base, 1);
    if (iss_cmd.size() > base) chk("t3_cmd5", iss_cmd[base], 5);

    // Controller that never acknowledges.
    force_busy = 1'b1;
    auto_ack = 1'b0;
    push(4'd2); push(4'd6);
    base = iss_cmd.size();
    e0 = err_cyc.size();
    force_busy = 1'b0;
    cycles(16);
    chk("t5_err_count", err_cyc.size() - e0, 2);
    chk("t5_issue_count", iss_cmd.size() - base, 2);
    if (err_cyc.size() >= e0 + 1 && iss_cmd.size() >= base + 2) begin
      chk("t5_err_latency", err_cyc[e0] - iss_cyc[base], ACK_TIMEOUT);
      chk("t5_next_cmd", iss_cmd[base + 1], 6);
      chk("t5_next_after_err", iss_cyc[base + 1] - err_cyc[e0], 1);
    end
    auto_ack = 1'b1;

    // Reset while held in WAIT_REL with five entries queued.
    force_busy = 1'b1;
    for (int i = 1; i <= 6; i++) push(4'(i));
    force_busy = 1'b0;
    @(negedge clk);
    force_busy = 1'b1;
    cycles(3);
    chk("t6_pre_count", fifo_count, 5);
    reset = 1'b1;
    #1;
    chk("t6_count", fifo_count, 0);
    chk("t6_in_ready", in_ready, 1);
    chk("t6_cmd", lcd_cmd, 0);
    chk("t6_valid", lcd_cmd_valid, 0);
    chk("t6_issued", issued_cnt, 0);
    chk("t6_err", ack_err, 0);
    chk("t6_drop", cmd_drop, 0);
    chk("t6_seq_done", seq_done, 0);
    @(negedge clk);
    reset = 1'b0;

    // Write command closes the input, then done completes the sequence.
    push(4'd9); push(4'd0);
    in_cmd = 4'd3;
    in_valid = 1'b1;
    cycles(3);
    in_valid = 1'b0;
    chk("t4_in_ready", in_ready, 0);
    chk("t4_count", fifo_count, 2);
    base = iss_cmd.size();
    force_busy = 1'b0;
    cycles(12);
    chk("t4_issues", iss_cmd.size() - base, 2);
    chk("t4_issued_cnt", issued_cnt, 2);
    chk("t4_not_done_yet", seq_done, 0);
    lcd_done = 1'b1;
    @(negedge clk);
    lcd_done = 1'b0;
    chk("t4_seq_done", seq_done, 1);
    cycles(5);
    chk("t4_seq_done_sticky", seq_done, 1);
    chk("t4_no_more_issue", iss_cmd.size() - base, 2);
    chk("t4_closed", in_ready, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
